// File: rtl/pad_conditioner.sv
// Conditions raw host joystick bitmaps into per-player pad lines: sync, SOCD cleaning, turbo.
// Latency SYNC_STAGES CLK plus the next CE edge; no backpressure, every register except the synchronisers holds while CE=0.
module pad_conditioner #(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        VBLANK,
  input  logic [11:0] JOY1,
  input  logic [11:0] JOY2,
  input  logic [11:0] JOY3,
  input  logic [11:0] JOY4,
  input  logic [3:0]  TURBO_EN,
  input  logic [5:0]  TURBO_MASK,
  input  logic [1:0]  TURBO_RATE,
  input  logic [1:0]  SOCD_MODE,
  output logic [11:0] P1,
  output logic [11:0] P2,
  output logic [11:0] P3,
  output logic [11:0] P4
);

  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_NEG  = 2'd1,
    LAST_POS  = 2'd2
  } last_t;

  logic [11:0] joy_raw     [4];
  logic [11:0] sync_q      [4][SYNC_STAGES];
  logic [11:0] joy_s       [4];
  logic [11:0] joy_prev    [4];
  logic [11:0] pad_q       [4];
  logic [11:0] pad_nxt     [4];
  logic [1:0]  lr_res      [4];
  logic [1:0]  ud_res      [4];
  last_t       last_lr     [4];
  last_t       last_ud     [4];
  last_t       last_lr_nxt [4];
  last_t       last_ud_nxt [4];

  logic        vblank_q;
  logic [3:0]  frame_cnt;
  logic        frame_tick;
  logic        phase;
  logic [11:0] turbo_bits;

  // Which direction of an axis most recently started being held.
  function automatic last_t last_update(input last_t cur, input logic neg, input logic pos,
                                        input logic neg_prev, input logic pos_prev);
    logic  neg_rise;
    logic  pos_rise;
    last_t nxt;
    neg_rise = neg & ~neg_prev;
    pos_rise = pos & ~pos_prev;
    nxt      = cur;
    if (!neg && !pos)
      nxt = LAST_NONE;
    else if (neg_rise && pos_rise)
      nxt = LAST_NONE;
    else if (pos_rise)
      nxt = LAST_POS;
    else if (neg_rise)
      nxt = LAST_NEG;
    return nxt;
  endfunction

  // Returns {neg, pos}; only a both-held axis is ever altered.
  function automatic logic [1:0] axis_resolve(input logic [1:0] mode, input last_t last,
                                              input logic neg, input logic pos);
    logic [1:0] res;
    res = {neg, pos};
    if (neg && pos) begin
      case (mode)
        2'd1: res = 2'b00;
        2'd2: begin
          case (last)
            LAST_NEG: res = 2'b10;
            LAST_POS: res = 2'b01;
            default:  res = 2'b00;
          endcase
        end
        default: res = {neg, pos};
      endcase
    end
    return res;
  endfunction

  assign joy_raw = '{JOY1, JOY2, JOY3, JOY4};

  assign frame_tick = CE & VBLANK & ~vblank_q;
  assign phase      = frame_cnt[TURBO_RATE];
  assign turbo_bits = {TURBO_MASK[5:3], 2'b00, TURBO_MASK[2:0], 4'b0000};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      joy_s[i]       = sync_q[i][SYNC_STAGES-1];
      // Bits: 0 RIGHT (pos), 1 LEFT (neg), 2 DOWN (pos), 3 UP (neg).
      last_lr_nxt[i] = last_update(last_lr[i], joy_s[i][1], joy_s[i][0],
                                   joy_prev[i][1], joy_prev[i][0]);
      last_ud_nxt[i] = last_update(last_ud[i], joy_s[i][3], joy_s[i][2],
                                   joy_prev[i][3], joy_prev[i][2]);
      lr_res[i]      = axis_resolve(SOCD_MODE, last_lr_nxt[i], joy_s[i][1], joy_s[i][0]);
      ud_res[i]      = axis_resolve(SOCD_MODE, last_ud_nxt[i], joy_s[i][3], joy_s[i][2]);
      pad_nxt[i]     = {joy_s[i][11:4], ud_res[i], lr_res[i]};
      if (TURBO_EN[i] && phase)
        pad_nxt[i] = pad_nxt[i] & ~turbo_bits;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vblank_q  <= 1'b0;
      frame_cnt <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        for (int s = 0; s < SYNC_STAGES; s++)
          sync_q[i][s] <= 12'd0;
        joy_prev[i] <= 12'd0;
        pad_q[i]    <= 12'd0;
        last_lr[i]  <= LAST_NONE;
        last_ud[i]  <= LAST_NONE;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i][0] <= joy_raw[i];
        for (int s = 1; s < SYNC_STAGES; s++)
          sync_q[i][s] <= sync_q[i][s-1];
      end
      if (CE) begin
        vblank_q <= VBLANK;
        if (frame_tick)
          frame_cnt <= frame_cnt + 4'd1;
        for (int i = 0; i < 4; i++) begin
          joy_prev[i] <= joy_s[i];
          last_lr[i]  <= last_lr_nxt[i];
          last_ud[i]  <= last_ud_nxt[i];
          pad_q[i]    <= pad_nxt[i];
        end
      end
    end
  end

  assign P1 = pad_q[0];
  assign P2 = pad_q[1];
  assign P3 = pad_q[2];
  assign P4 = pad_q[3];

endmodule

// File: tb/tb_pad_conditioner.sv
// Directed bench for pad_conditioner: latency, turbo, SOCD modes, CE gating and mid-run reset.
module tb_pad_conditioner;

  logic        CLK;
  logic        RESET;
  logic        CE;
  logic        VBLANK;
  logic [11:0] JOY1, JOY2, JOY3, JOY4;
  logic [3:0]  TURBO_EN;
  logic [5:0]  TURBO_MASK;
  logic [1:0]  TURBO_RATE;
  logic [1:0]  SOCD_MODE;
  logic [11:0] P1, P2, P3, P4;

  int checks = 0;
  int errors = 0;
  logic [5:0] turbo_pat;

  pad_conditioner #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .VBLANK(VBLANK),
    .JOY1(JOY1), .JOY2(JOY2), .JOY3(JOY3), .JOY4(JOY4),
    .TURBO_EN(TURBO_EN), .TURBO_MASK(TURBO_MASK), .TURBO_RATE(TURBO_RATE),
    .SOCD_MODE(SOCD_MODE),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b0; VBLANK = 1'b0;
    JOY1 = '0; JOY2 = '0; JOY3 = '0; JOY4 = '0;
    TURBO_EN = '0; TURBO_MASK = '0; TURBO_RATE = '0; SOCD_MODE = '0;
    turbo_pat = 6'b110011;  // bit k = expected A at frame count k, rate 1

    // Reset applies even with CE low
    tick(2);
    check("rst_p1", P1, 12'h000);
    check("rst_p2", P2, 12'h000);
    check("rst_p3", P3, 12'h000);
    check("rst_p4", P4, 12'h000);
    check("rst_cnt", {8'd0, dut.frame_cnt}, 12'h000);

    // Passthrough latency: visible on the 3rd edge only
    RESET = 1'b0; CE = 1'b1; JOY1 = 12'h0A5;
    tick(1); check("pass_e1", P1, 12'h000);
    tick(1); check("pass_e2", P1, 12'h000);
    tick(1); check("pass_e3", P1, 12'h0A5);
    JOY1 = 12'h000;
    tick(3); check("pass_clr", P1, 12'h000);

    // Turbo on A for player 1 only, rate 1
    TURBO_EN = 4'b0001; TURBO_MASK = 6'b000001; TURBO_RATE = 2'd1;
    JOY1 = 12'h010; JOY2 = 12'h010;
    tick(3);
    check("turbo_p1_f0", P1, 12'h010);
    check("turbo_p2_f0", P2, 12'h010);
    for (int k = 1; k <= 5; k++) begin
      VBLANK = 1'b1; tick(2);   // held high two CE cycles: one tick only
      VBLANK = 1'b0; tick(1);
      check($sformatf("turbo_p1_f%0d", k), {11'd0, P1[4]}, {11'd0, turbo_pat[k]});
      check($sformatf("turbo_p2_f%0d", k), {11'd0, P2[4]}, 12'h001);
    end
    check("turbo_cnt", {8'd0, dut.frame_cnt}, 12'h005);
    TURBO_EN = 4'b0000; JOY1 = 12'h000; JOY2 = 12'h000;
    tick(3);

    // SOCD last-input-wins on LEFT/RIGHT
    SOCD_MODE = 2'd2;
    JOY1 = 12'h002;
    tick(3); check("lw_left", P1, 12'h002);
    JOY1 = 12'h003;
    tick(2); check("lw_right_e2", P1, 12'h002);
    tick(1); check("lw_right", P1, 12'h001);
    JOY1 = 12'h002;
    tick(3); check("lw_rel_right", P1, 12'h002);
    JOY1 = 12'h000;
    tick(3); check("lw_rel_all", P1, 12'h000);

    // Simultaneous press on both axes, then mode changes while held
    JOY1 = 12'h00F;
    tick(3); check("simul_m2", P1, 12'h000);
    SOCD_MODE = 2'd0; tick(1); check("held_m0", P1, 12'h00F);
    SOCD_MODE = 2'd1; tick(1); check("held_m1", P1, 12'h000);
    SOCD_MODE = 2'd3; tick(1); check("held_m3", P1, 12'h00F);
    SOCD_MODE = 2'd2; tick(1); check("held_m2_none", P1, 12'h000);
    JOY1 = 12'h000;
    tick(3);

    // UP/DOWN axis last-wins
    JOY1 = 12'h008;
    tick(3); check("ud_up", P1, 12'h008);
    JOY1 = 12'h00C;
    tick(3); check("ud_down", P1, 12'h004);
    JOY1 = 12'h000;
    tick(3);

    // CE gating: output and frame counter frozen while CE low
    SOCD_MODE = 2'd0;
    CE = 1'b0; JOY2 = 12'h080;
    tick(4);
    VBLANK = 1'b1; tick(2); VBLANK = 1'b0;
    tick(4);
    check("ce_hold_p2", P2, 12'h000);
    check("ce_hold_cnt", {8'd0, dut.frame_cnt}, 12'h005);
    CE = 1'b1;
    tick(1); check("ce_resume_p2", P2, 12'h080);
    check("ce_resume_cnt", {8'd0, dut.frame_cnt}, 12'h005);

    // Mid-operation reset with everything held
    JOY1 = 12'hFF0; JOY2 = 12'hFF0; JOY3 = 12'hFF0; JOY4 = 12'hFF0;
    tick(3);
    check("pre_rst_p3", P3, 12'hFF0);
    RESET = 1'b1; tick(1); RESET = 1'b0;
    check("mrst_p1", P1, 12'h000);
    check("mrst_p2", P2, 12'h000);
    check("mrst_p3", P3, 12'h000);
    check("mrst_p4", P4, 12'h000);
    check("mrst_cnt", {8'd0, dut.frame_cnt}, 12'h000);
    tick(2); check("mrst_lat_e2", P1, 12'h000);
    tick(1);
    check("mrst_back_p1", P1, 12'hFF0);
    check("mrst_back_p2", P2, 12'hFF0);
    check("mrst_back_p3", P3, 12'hFF0);
    check("mrst_back_p4", P4, 12'hFF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
